// File: rtl/tap_controller.sv
// tap_controller -- IEEE 1149.1 TAP state machine with its instruction register.
//
// Ports:
//   tck_i            test clock; state, IR shift and instruction update on rising edge
//   trst_ni          asynchronous active-low test reset
//   tms_i            test mode select, sampled on rising tck_i
//   tdi_i            serial test data in
//   drTdo_i          serial out of the currently selected data register (muxed outside)
//   tdo_o            serial test data out, launched on falling tck_i
//   tdoEnable_o      high while tdo_o carries shift data
//   state_o          current TAP state (0..15, TLR..UPD_IR)
//   irInstruction_o  active instruction for the instruction decoder
//   captureDR_o      high in Capture-DR
//   shiftDR_o        high in Shift-DR
//   updateDR_o       high in Update-DR
//   testLogicReset_o high in Test-Logic-Reset

package tap_pkg;
  parameter int unsigned instruction_width = 4;
  parameter logic [instruction_width-1:0] BYPASS = '1;
endpackage

module tap_controller #(
  parameter int unsigned IR_WIDTH = tap_pkg::instruction_width,
  parameter logic [IR_WIDTH-1:0] IR_RESET = tap_pkg::BYPASS
) (
  input  logic                tck_i,
  input  logic                trst_ni,
  input  logic                tms_i,
  input  logic                tdi_i,
  input  logic                drTdo_i,
  output logic                tdo_o,
  output logic                tdoEnable_o,
  output logic [3:0]          state_o,
  output logic [IR_WIDTH-1:0] irInstruction_o,
  output logic                captureDR_o,
  output logic                shiftDR_o,
  output logic                updateDR_o,
  output logic                testLogicReset_o
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  // Fixed pattern captured into the IR: the two LSBs 01 let a board-level
  // scan verify IR chain integrity.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_e          state;
  tap_state_e          next_state;
  logic [IR_WIDTH-1:0] ir_shift;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state <= TLR;
    end else begin
      state <= next_state;
    end
  end

  // The DR and IR columns of the diagram are symmetric; holding TMS high
  // always funnels back towards TLR within five edges.
  always_comb begin
    next_state       = state;
    captureDR_o      = 1'b0;
    shiftDR_o        = 1'b0;
    updateDR_o       = 1'b0;
    testLogicReset_o = 1'b0;
    case (state)
      TLR:     next_state = tms_i ? TLR    : RTI;
      RTI:     next_state = tms_i ? SEL_DR : RTI;
      SEL_DR:  next_state = tms_i ? SEL_IR : CAP_DR;
      CAP_DR:  next_state = tms_i ? EX1_DR : SH_DR;
      SH_DR:   next_state = tms_i ? EX1_DR : SH_DR;
      EX1_DR:  next_state = tms_i ? UPD_DR : PAU_DR;
      PAU_DR:  next_state = tms_i ? EX2_DR : PAU_DR;
      EX2_DR:  next_state = tms_i ? UPD_DR : SH_DR;
      UPD_DR:  next_state = tms_i ? SEL_DR : RTI;
      SEL_IR:  next_state = tms_i ? TLR    : CAP_IR;
      CAP_IR:  next_state = tms_i ? EX1_IR : SH_IR;
      SH_IR:   next_state = tms_i ? EX1_IR : SH_IR;
      EX1_IR:  next_state = tms_i ? UPD_IR : PAU_IR;
      PAU_IR:  next_state = tms_i ? EX2_IR : PAU_IR;
      EX2_IR:  next_state = tms_i ? UPD_IR : SH_IR;
      UPD_IR:  next_state = tms_i ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
    captureDR_o      = (state == CAP_DR);
    shiftDR_o        = (state == SH_DR);
    updateDR_o       = (state == UPD_DR);
    testLogicReset_o = (state == TLR);
  end

  // IR shift stage: loads the capture pattern leaving CAP_IR, shifts towards
  // bit 0 in SH_IR, and is frozen everywhere else (including the pause states).
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_shift <= '0;
    end else if (state == CAP_IR) begin
      ir_shift <= IR_CAPTURE;
    end else if (state == SH_IR) begin
      ir_shift <= {tdi_i, ir_shift[IR_WIDTH-1:1]};
    end
  end

  // The active instruction only changes in UPD_IR, so a partially shifted
  // value never reaches the decoder; TLR forces the reset instruction.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      irInstruction_o <= IR_RESET;
    end else if (state == TLR) begin
      irInstruction_o <= IR_RESET;
    end else if (state == UPD_IR) begin
      irInstruction_o <= ir_shift;
    end
  end

  // TDO launches on the falling edge so the downstream device sees half a
  // cycle of setup before its own rising-edge sample.
  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      tdo_o       <= 1'b0;
      tdoEnable_o <= 1'b0;
    end else if (state == SH_IR) begin
      tdo_o       <= ir_shift[0];
      tdoEnable_o <= 1'b1;
    end else if (state == SH_DR) begin
      tdo_o       <= drTdo_i;
      tdoEnable_o <= 1'b1;
    end else begin
      tdo_o       <= 1'b0;
      tdoEnable_o <= 1'b0;
    end
  end

  assign state_o = state;

endmodule
